// File: rtl/lb_event_fifo.sv
// Local-bus event recorder: captures changes of a 32-bit event vector into a
// FIFO while armed; host drains it through a control/data register pair.
module lb_event_fifo #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [7:0]  CTRL_ADDR  = 8'h90,
    parameter logic [7:0]  DATA_ADDR  = 8'h94
) (
    input  logic        clk_lb,
    input  logic        reset_n,
    input  logic        lb_wr,
    input  logic        lb_rd,
    input  logic [7:0]  lb_addr,
    input  logic [31:0] lb_wr_d,
    output logic [31:0] lb_rd_d,
    output logic        lb_rd_rdy,
    input  logic [31:0] events
);

    localparam int                DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  armed, ovf;
    logic [31:0]           events_p1;
    logic [31:0]           ram_q, sts_q, rd_word;
    logic                  sel_ctrl_q, sel_nz_q, pop_pend;
    logic [2:0]            vld_pipe;

    logic        ctrl_wr, clr, full, empty, push, push_ok, pop_now, rd_hit;
    logic [31:0] status;

    assign ctrl_wr = lb_wr && (lb_addr == CTRL_ADDR);
    assign clr     = ctrl_wr && lb_wr_d[1];
    assign full    = (count == FULL);
    assign empty   = (count == '0);
    assign push    = armed && (events != events_p1) && !clr;
    assign push_ok = push && !full;
    assign pop_now = pop_pend && !clr;
    // A new read is accepted only once the previous one has left stages 0/1.
    assign rd_hit  = lb_rd && ((lb_addr == CTRL_ADDR) || (lb_addr == DATA_ADDR))
                     && !(vld_pipe[0] || vld_pipe[1]);
    assign status  = {ovf, armed, empty, 13'b0, {(15-DEPTH_LOG2){1'b0}}, count};
    assign lb_rd_rdy = vld_pipe[2];

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            armed      <= 1'b0;
            ovf        <= 1'b0;
            events_p1  <= '0;
            sts_q      <= '0;
            rd_word    <= '0;
            sel_ctrl_q <= 1'b0;
            sel_nz_q   <= 1'b0;
            pop_pend   <= 1'b0;
            vld_pipe   <= '0;
            lb_rd_d    <= '0;
        end else begin
            events_p1 <= events;
            vld_pipe  <= {vld_pipe[1:0], rd_hit};
            if (ctrl_wr)
                armed <= lb_wr_d[0];
            if (rd_hit) begin
                sel_ctrl_q <= (lb_addr == CTRL_ADDR);
                sel_nz_q   <= !empty;
                sts_q      <= status;
            end
            // A clear on the read edge cancels the pop; the old word still returns.
            pop_pend <= rd_hit && (lb_addr == DATA_ADDR) && !empty && !clr;
            if (vld_pipe[0])
                rd_word <= sel_ctrl_q ? sts_q : (sel_nz_q ? ram_q : 32'h0);
            lb_rd_d <= vld_pipe[1] ? rd_word : 32'h0;

            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf    <= 1'b0;
            end else begin
                if (push && full)
                    ovf <= 1'b1;
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop_now)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop_now})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Simple dual-port RAM with registered read, block-RAM inferable.
    always_ff @(posedge clk_lb) begin
        if (push_ok)
            mem[wr_ptr] <= events;
        if (rd_hit)
            ram_q <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_lb_event_fifo.sv
// Randomized + directed bench for lb_event_fifo against a queue-based model.
module tb_lb_event_fifo;

    localparam int         DL    = 4;
    localparam int         DEPTH = 1 << DL;
    localparam logic [7:0] CTRL  = 8'h90;
    localparam logic [7:0] DATA  = 8'h94;

    logic        clk_lb = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr = 1'b0, rd = 1'b0;
    logic [7:0]  addr = 8'h0;
    logic [31:0] wd = 32'h0, ev = 32'h0;
    logic [31:0] lb_rd_d;
    logic        lb_rd_rdy;

    lb_event_fifo #(.DEPTH_LOG2(DL), .CTRL_ADDR(CTRL), .DATA_ADDR(DATA)) dut (
        .clk_lb(clk_lb), .reset_n(reset_n), .lb_wr(wr), .lb_rd(rd),
        .lb_addr(addr), .lb_wr_d(wd), .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy),
        .events(ev)
    );

    always #5 clk_lb = ~clk_lb;

    int checks = 0, errors = 0;

    // Reference model state
    logic [31:0] q[$];
    bit          m_armed, m_ovf, m_pend;
    logic [31:0] m_prev;
    int          n = 0, due = -10;
    logic [31:0] due_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_armed = 0; m_ovf = 0; m_pend = 0; m_prev = 0; due = -10;
    endtask

    // One bus cycle: update the model at the rising edge, check outputs at the falling edge.
    task automatic step();
        bit ctrl_wr, clr, hit, push, new_pend;
        @(posedge clk_lb);
        n++;
        ctrl_wr  = wr && addr == CTRL;
        clr      = ctrl_wr && wd[1];
        hit      = rd && (addr == CTRL || addr == DATA) && n > due;
        new_pend = 0;
        if (hit) begin
            due = n + 2;
            if (addr == CTRL)
                due_val = {m_ovf, m_armed, q.size() == 0, 13'b0, 16'(q.size())};
            else if (q.size() > 0) begin
                due_val = q[0];
                new_pend = 1;
            end else
                due_val = 32'h0;
        end
        push = m_armed && ev != m_prev && !clr;
        if (push) begin
            if (q.size() == DEPTH) m_ovf = 1;
            else q.push_back(ev);
        end
        if (m_pend && !clr) void'(q.pop_front());
        if (clr) begin
            q.delete();
            m_ovf = 0;
        end
        if (ctrl_wr) m_armed = wd[0];
        m_pend = new_pend && !clr;
        m_prev = ev;
        @(negedge clk_lb);
        chk("rdy", {31'b0, lb_rd_rdy}, {31'b0, n == due});
        chk("rd_d", lb_rd_d, (n == due) ? due_val : 32'h0);
        wr = 0;
        rd = 0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        wr = 1; addr = a; wd = d;
        step();
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] v);
        rd = 1; addr = a;
        step(); step(); step();
        v = lb_rd_d;
    endtask

    logic [31:0] v;
    logic [31:0] exp_list[$];

    initial begin
        model_reset();
        repeat (3) @(negedge clk_lb);
        chk("rst_rdy", {31'b0, lb_rd_rdy}, 32'h0);
        chk("rst_d", lb_rd_d, 32'h0);
        reset_n = 1;

        // Reset status
        rd_reg(CTRL, v); chk("sts_reset", v, 32'h2000_0000);

        // Basic capture
        wr_reg(CTRL, 32'h1);
        ev = 0; step(); ev = 5; step(); ev = 5; step(); ev = 9; step();
        rd_reg(CTRL, v); chk("sts_basic", v, 32'h4000_0002);
        rd_reg(DATA, v); chk("data5", v, 32'd5);
        rd_reg(DATA, v); chk("data9", v, 32'd9);
        rd_reg(DATA, v); chk("data_empty", v, 32'h0);
        rd_reg(CTRL, v); chk("sts_empty", v, 32'h6000_0000);

        // Overflow
        wr_reg(CTRL, 32'h3);
        for (int i = 1; i <= 20; i++) begin ev = i; step(); end
        rd_reg(CTRL, v); chk("sts_ovf", v, 32'hC000_0010);
        for (int i = 1; i <= 16; i++) begin rd_reg(DATA, v); chk("ovf_data", v, i); end
        wr_reg(CTRL, 32'h3);
        rd_reg(CTRL, v); chk("sts_clr", v, 32'h6000_0000);

        // Wrap-around
        for (int i = 0; i < 12; i++) begin ev = 100 + i; step(); end
        for (int i = 0; i < 10; i++) begin rd_reg(DATA, v); chk("wrap_a", v, 100 + i); end
        for (int i = 0; i < 12; i++) begin ev = 200 + i; step(); end
        exp_list = {32'd110, 32'd111};
        for (int i = 0; i < 12; i++) exp_list.push_back(200 + i);
        for (int i = 0; i < 14; i++) begin
            if (i == 13) begin rd_reg(CTRL, v); chk("wrap_cnt1", v, 32'h4000_0001); end
            rd_reg(DATA, v); chk("wrap_b", v, exp_list[i]);
        end
        rd_reg(CTRL, v); chk("wrap_cnt0", v, 32'h6000_0000);

        // Push and pop in the same cycle, then clear racing an event change
        for (int i = 0; i < 3; i++) begin ev = 300 + i; step(); end
        rd = 1; addr = DATA; step();
        ev = 303; step();
        step(); chk("pp_data", lb_rd_d, 32'd300);
        rd_reg(CTRL, v); chk("pp_cnt", v, 32'h4000_0003);
        ev = 400; wr_reg(CTRL, 32'h3);
        rd_reg(CTRL, v); chk("clr_race", v, 32'h6000_0000);

        // Reset mid-read
        ev = 500; step();
        rd = 1; addr = DATA; step();
        #1 reset_n = 0;
        rd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_lb);
            chk("mid_rdy", {31'b0, lb_rd_rdy}, 32'h0);
            chk("mid_d", lb_rd_d, 32'h0);
        end
        model_reset();
        reset_n = 1;
        rd_reg(CTRL, v); chk("sts_after_rst", v, 32'h2000_0000);

        // Foreign address
        rd = 1; addr = 8'h98;
        for (int i = 0; i < 3; i++) begin step(); chk("dec98", {31'b0, lb_rd_rdy}, 32'h0); end

        // Randomized traffic checked cycle by cycle against the model
        wr_reg(CTRL, 32'h1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 1) ev = $urandom_range(0, 7);
            if ($urandom_range(0, 99) < 35) begin
                rd = 1;
                case ($urandom_range(0, 3))
                    0: addr = CTRL;
                    1, 2: addr = DATA;
                    default: addr = 8'h98;
                endcase
            end
            if ($urandom_range(0, 99) < 6) begin
                wr = 1;
                addr = ($urandom_range(0, 3) == 0) ? DATA : CTRL;
                wd = {$urandom, 2'b00} | {30'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)};
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
